// File: rtl/multiword_spi_slave_pkg.sv
// Shared types and constants for the multi-word SPI slave.
// Transfer FSM states and synchroniser depth.
package multiword_spi_slave_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_DISARMED,
    ST_ARMED,
    ST_ACTIVE
  } xfer_state_e;

endpackage

// File: rtl/multiword_spi_slave_sync.sv
// Metastability synchroniser for one async pin plus a history flop
// so the caller can detect edges as sync_o != hist_o.
module pin_synchronizer #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic sync_o,
  output logic hist_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Shift the pin through the sync chain, then remember the last value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VALUE}};
      hist_q <= RESET_VALUE;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign hist_o = hist_q;

endmodule

// File: rtl/multiword_spi_slave.sv
// SPI slave oversampled by system_clk; streams WIDTH-bit words for as
// long as chip select stays low, all four SPI modes, MSB or LSB first.
module multiword_spi_slave
  import multiword_spi_slave_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic             system_clk,
  input  logic             system_rst,
  input  logic             pin_ncs,
  input  logic             pin_clk,
  input  logic             pin_mosi,
  output logic             pin_miso,
  output logic             pin_miso_en,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_load,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             cs_start,
  output logic             cs_stop,
  output logic             rx_abort
);

  localparam int   CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic IDLE_CLK  = (CPOL != 0);
  localparam logic LEAD_RISE = (CPOL == 0);
  localparam logic SAMP_LEAD = (CPHA == 0);
  localparam logic LSB       = (LSB_FIRST != 0);

  logic ncs_s, ncs_h;
  logic clk_s, clk_h;
  logic mosi_s, mosi_hist_unused;

  pin_synchronizer #(
    .STAGES     (SYNC_STAGES),
    .RESET_VALUE(1'b1)
  ) u_sync_ncs (
    .clk_i (system_clk),
    .rst_i (system_rst),
    .pin_i (pin_ncs),
    .sync_o(ncs_s),
    .hist_o(ncs_h)
  );

  pin_synchronizer #(
    .STAGES     (SYNC_STAGES),
    .RESET_VALUE(IDLE_CLK)
  ) u_sync_clk (
    .clk_i (system_clk),
    .rst_i (system_rst),
    .pin_i (pin_clk),
    .sync_o(clk_s),
    .hist_o(clk_h)
  );

  pin_synchronizer #(
    .STAGES     (SYNC_STAGES),
    .RESET_VALUE(1'b0)
  ) u_sync_mosi (
    .clk_i (system_clk),
    .rst_i (system_rst),
    .pin_i (pin_mosi),
    .sync_o(mosi_s),
    .hist_o(mosi_hist_unused)
  );

  xfer_state_e      state_q;
  logic [1:0]       arm_cnt_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] tx_q;
  logic             word_done_q;
  logic             first_q;
  logic             active_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             cs_start_q;
  logic             cs_stop_q;
  logic             rx_abort_q;

  logic clk_rise, clk_fall;
  logic lead_edge, trail_edge;
  logic sample_edge, launch_edge;
  logic ncs_fall, ncs_rise;
  logic start_ev, running;
  logic samp, launch, last_bit;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_shift;

  // Edge decode from the synchronised pins and the mode constants.
  always_comb begin
    clk_rise    = clk_s & ~clk_h;
    clk_fall    = ~clk_s & clk_h;
    lead_edge   = LEAD_RISE ? clk_rise : clk_fall;
    trail_edge  = LEAD_RISE ? clk_fall : clk_rise;
    sample_edge = SAMP_LEAD ? lead_edge : trail_edge;
    launch_edge = SAMP_LEAD ? trail_edge : lead_edge;
    ncs_fall    = ~ncs_s & ncs_h;
    ncs_rise    = ncs_s & ~ncs_h;
    start_ev    = (state_q == ST_ARMED) & ncs_fall;
    running     = (state_q == ST_ACTIVE) & ~ncs_rise;
    samp        = running & sample_edge;
    launch      = running & launch_edge;
    last_bit    = (cnt_q == CW'(WIDTH - 1));
    rx_next     = LSB ? {mosi_s, rx_q[WIDTH-1:1]}
                      : {rx_q[WIDTH-2:0], mosi_s};
    tx_shift    = LSB ? {1'b0, tx_q[WIDTH-1:1]}
                      : {tx_q[WIDTH-2:0], 1'b0};
  end

  // tx_load marks the cycle whose closing edge captures tx_data.
  always_comb begin
    tx_load = 1'b0;
    if (!system_rst) begin
      if (start_ev) begin
        tx_load = 1'b1;
      end else if (SAMP_LEAD) begin
        tx_load = launch & word_done_q;
      end else begin
        tx_load = samp & last_bit;
      end
    end
  end

  // Transfer FSM: arming, word reception, tx launch and status pulses.
  always_ff @(posedge system_clk) begin
    if (system_rst) begin
      state_q     <= ST_DISARMED;
      arm_cnt_q   <= '0;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      word_done_q <= 1'b0;
      first_q     <= 1'b0;
      active_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      cs_start_q  <= 1'b0;
      cs_stop_q   <= 1'b0;
      rx_abort_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      cs_start_q <= 1'b0;
      cs_stop_q  <= 1'b0;
      rx_abort_q <= 1'b0;
      unique case (state_q)
        ST_DISARMED: begin
          // Require a genuinely high ncs, not just the preset chain.
          if (ncs_s) begin
            if (arm_cnt_q == 2'(SYNC_STAGES)) begin
              state_q   <= ST_ARMED;
              arm_cnt_q <= '0;
            end else begin
              arm_cnt_q <= arm_cnt_q + 2'd1;
            end
          end else begin
            arm_cnt_q <= '0;
          end
        end
        ST_ARMED: begin
          if (ncs_fall) begin
            state_q     <= ST_ACTIVE;
            active_q    <= 1'b1;
            cs_start_q  <= 1'b1;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= tx_data;
            word_done_q <= 1'b0;
            first_q     <= ~SAMP_LEAD;
          end
        end
        ST_ACTIVE: begin
          if (ncs_rise) begin
            state_q     <= ST_ARMED;
            active_q    <= 1'b0;
            cs_stop_q   <= 1'b1;
            rx_abort_q  <= (cnt_q != '0);
            cnt_q       <= '0;
            word_done_q <= 1'b0;
            first_q     <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_q <= rx_next;
              if (last_bit) begin
                cnt_q      <= '0;
                rx_data_q  <= rx_next;
                rx_valid_q <= 1'b1;
                if (SAMP_LEAD) begin
                  word_done_q <= 1'b1;
                end else begin
                  tx_q    <= tx_data;
                  first_q <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
            if (launch_edge) begin
              if (SAMP_LEAD) begin
                if (word_done_q) begin
                  tx_q        <= tx_data;
                  word_done_q <= 1'b0;
                end else begin
                  tx_q <= tx_shift;
                end
              end else begin
                if (first_q) begin
                  first_q <= 1'b0;
                end else begin
                  tx_q <= tx_shift;
                end
              end
            end
          end
        end
        default: begin
          state_q  <= ST_DISARMED;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign pin_miso    = LSB ? tx_q[0] : tx_q[WIDTH-1];
  assign pin_miso_en = active_q & ~pin_ncs;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign cs_start    = cs_start_q;
  assign cs_stop     = cs_stop_q;
  assign rx_abort    = rx_abort_q;

endmodule
